// File: rtl/time_mode_controller.sv
// Clock / time-set / stopwatch mode sequencer for the six-digit display.
// Owns the time-of-day and stopwatch counters; all outputs are registered.
module time_mode_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_tenth,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_start,
    output logic [20:0] out_time,
    output logic [2:0]  flash,
    output logic        display_mode
);

    typedef enum logic [2:0] {
        CLOCK,
        SET_H,
        SET_M,
        SET_S,
        STOPWATCH
    } state_t;

    typedef struct packed {
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic [3:0] t;
    } time_t;

    state_t state_q, state_d;
    time_t  tod_q, tod_d;
    time_t  sw_q, sw_d;
    logic   sw_run_q, sw_run_d;

    logic [20:0] out_time_d;
    logic [2:0]  flash_d;
    logic        display_mode_d;

    logic press_mode, press_next, press_inc;
    logic in_set, set_exit, in_sw;

    function automatic time_t time_inc(input time_t v);
        time_t r;
        r = v;
        if (v.t == 4'd9) begin
            r.t = 4'd0;
            if (v.ss == 6'd59) begin
                r.ss = 6'd0;
                if (v.mm == 6'd59) begin
                    r.mm = 6'd0;
                    r.hh = (v.hh == 5'd23) ? 5'd0 : v.hh + 5'd1;
                end else begin
                    r.mm = v.mm + 6'd1;
                end
            end else begin
                r.ss = v.ss + 6'd1;
            end
        end else begin
            r.t = v.t + 4'd1;
        end
        return r;
    endfunction

    // Only the highest-priority button of a cycle is acted on.
    always_comb begin
        press_mode = 1'b0;
        press_next = 1'b0;
        press_inc  = 1'b0;
        priority case (1'b1)
            btn_mode: press_mode = 1'b1;
            btn_next: press_next = 1'b1;
            btn_inc:  press_inc  = 1'b1;
            default: ;
        endcase
    end

    assign in_set = (state_q == SET_H) || (state_q == SET_M) ||
                    (state_q == SET_S);
    assign in_sw  = (state_q == STOPWATCH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CLOCK;
            tod_q    <= '0;
            sw_q     <= '0;
            sw_run_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tod_q    <= tod_d;
            sw_q     <= sw_d;
            sw_run_q <= sw_run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLOCK: begin
                if (press_mode)      state_d = STOPWATCH;
                else if (press_next) state_d = SET_H;
            end
            SET_H: begin
                if (press_mode)      state_d = CLOCK;
                else if (press_next) state_d = SET_M;
            end
            SET_M: begin
                if (press_mode)      state_d = CLOCK;
                else if (press_next) state_d = SET_S;
            end
            SET_S: begin
                if (press_mode || press_next) state_d = CLOCK;
            end
            STOPWATCH: begin
                if (press_mode) state_d = CLOCK;
            end
            default: state_d = CLOCK;
        endcase
    end

    assign set_exit = in_set && (state_d == CLOCK);

    // tod is frozen while setting; inc edits one field without carry.
    always_comb begin
        tod_d = tod_q;
        unique case (state_q)
            CLOCK, STOPWATCH: begin
                if (tick_tenth) tod_d = time_inc(tod_q);
            end
            SET_H: begin
                if (press_inc)
                    tod_d.hh = (tod_q.hh == 5'd23) ? 5'd0 : tod_q.hh + 5'd1;
            end
            SET_M: begin
                if (press_inc)
                    tod_d.mm = (tod_q.mm == 6'd59) ? 6'd0 : tod_q.mm + 6'd1;
            end
            SET_S: begin
                if (press_inc)
                    tod_d.ss = (tod_q.ss == 6'd59) ? 6'd0 : tod_q.ss + 6'd1;
            end
            default: ;
        endcase
        if (set_exit) tod_d.t = 4'd0;
    end

    always_comb begin
        sw_d = sw_q;
        if (in_sw && press_inc && !sw_run_q)
            sw_d = '0;
        else if (sw_run_q && tick_tenth)
            sw_d = time_inc(sw_q);
    end

    assign sw_run_d = sw_run_q ^ (in_sw && btn_start);

    always_comb begin
        out_time_d     = tod_q;
        flash_d        = 3'b000;
        display_mode_d = 1'b0;
        unique case (state_q)
            SET_H: flash_d = 3'b100;
            SET_M: flash_d = 3'b010;
            SET_S: flash_d = 3'b001;
            STOPWATCH: begin
                out_time_d     = sw_q;
                display_mode_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_time     <= '0;
            flash        <= 3'b000;
            display_mode <= 1'b0;
        end else begin
            out_time     <= out_time_d;
            flash        <= flash_d;
            display_mode <= display_mode_d;
        end
    end

endmodule

// File: tb/tb_time_mode_controller.sv
// Directed bench for time_mode_controller.
// Drives inputs and samples outputs on the falling edge.
module tb_time_mode_controller;

    logic        clk;
    logic        reset_n;
    logic        tick_tenth;
    logic        btn_mode;
    logic        btn_next;
    logic        btn_inc;
    logic        btn_start;
    logic [20:0] out_time;
    logic [2:0]  flash;
    logic        display_mode;

    int n_checks = 0;
    int n_fail   = 0;

    time_mode_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_tenth   (tick_tenth),
        .btn_mode     (btn_mode),
        .btn_next     (btn_next),
        .btn_inc      (btn_inc),
        .btn_start    (btn_start),
        .out_time     (out_time),
        .flash        (flash),
        .display_mode (display_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] tv(input int h, m, s, t);
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic [3:0] tt;
        hh = h[4:0];
        mm = m[5:0];
        ss = s[5:0];
        tt = t[3:0];
        return {hh, mm, ss, tt};
    endfunction

    task automatic pulse(input logic m, n, i, s, t);
        btn_mode   = m;
        btn_next   = n;
        btn_inc    = i;
        btn_start  = s;
        tick_tenth = t;
        @(negedge clk);
        btn_mode   = 1'b0;
        btn_next   = 1'b0;
        btn_inc    = 1'b0;
        btn_start  = 1'b0;
        tick_tenth = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse(0, 0, 0, 0, 1);
    endtask

    task automatic incs(input int n);
        repeat (n) pulse(0, 0, 1, 0, 0);
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        tick_tenth = 1'b0;
        btn_mode   = 1'b0;
        btn_next   = 1'b0;
        btn_inc    = 1'b0;
        btn_start  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_time !== 21'd0) begin
            $display("FAIL reset_time got %h want 0", out_time);
            n_fail++;
        end
        n_checks++;
        if (flash !== 3'b000) begin
            $display("FAIL reset_flash got %b want 000", flash);
            n_fail++;
        end
        n_checks++;
        if (display_mode !== 1'b0) begin
            $display("FAIL reset_mode got %b want 0", display_mode);
            n_fail++;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_tick();
        ticks(10);
        idle();
        n_checks++;
        if (out_time !== tv(0, 0, 1, 0)) begin
            $display("FAIL tick_time got %h want %h",
                     out_time, tv(0, 0, 1, 0));
            n_fail++;
        end
        n_checks++;
        if (flash !== 3'b000 || display_mode !== 1'b0) begin
            $display("FAIL tick_flags got %b/%b want 000/0",
                     flash, display_mode);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        pulse(0, 1, 0, 0, 0);
        incs(23);
        pulse(0, 1, 0, 0, 0);
        incs(59);
        pulse(0, 1, 0, 0, 0);
        incs(58);
        idle();
        n_checks++;
        if (out_time !== tv(23, 59, 59, 0) || flash !== 3'b001) begin
            $display("FAIL set_hms got %h/%b want %h/001",
                     out_time, flash, tv(23, 59, 59, 0));
            n_fail++;
        end
        incs(1);
        idle();
        n_checks++;
        if (out_time !== tv(23, 59, 0, 0)) begin
            $display("FAIL ss_wrap got %h want %h",
                     out_time, tv(23, 59, 0, 0));
            n_fail++;
        end
        incs(59);
        pulse(0, 1, 0, 0, 0);
        ticks(9);
        idle();
        n_checks++;
        if (out_time !== tv(23, 59, 59, 9)) begin
            $display("FAIL pre_wrap got %h want %h",
                     out_time, tv(23, 59, 59, 9));
            n_fail++;
        end
        ticks(1);
        idle();
        n_checks++;
        if (out_time !== 21'd0 || flash !== 3'b000) begin
            $display("FAIL full_wrap got %h/%b want 0/000",
                     out_time, flash);
            n_fail++;
        end
    endtask

    task automatic test_set_h();
        pulse(0, 1, 0, 0, 0);
        incs(25);
        idle();
        n_checks++;
        if (out_time !== tv(1, 0, 0, 0) || flash !== 3'b100) begin
            $display("FAIL hh_wrap got %h/%b want %h/100",
                     out_time, flash, tv(1, 0, 0, 0));
            n_fail++;
        end
        ticks(5);
        idle();
        n_checks++;
        if (out_time !== tv(1, 0, 0, 0)) begin
            $display("FAIL set_frozen got %h want %h",
                     out_time, tv(1, 0, 0, 0));
            n_fail++;
        end
        pulse(0, 0, 1, 0, 1);
        idle();
        n_checks++;
        if (out_time !== tv(2, 0, 0, 0)) begin
            $display("FAIL inc_tick got %h want %h",
                     out_time, tv(2, 0, 0, 0));
            n_fail++;
        end
        pulse(0, 1, 0, 0, 0);
        idle();
        n_checks++;
        if (flash !== 3'b010) begin
            $display("FAIL flash_m got %b want 010", flash);
            n_fail++;
        end
        pulse(1, 0, 0, 0, 0);
        idle();
        n_checks++;
        if (out_time !== tv(2, 0, 0, 0) || flash !== 3'b000) begin
            $display("FAIL mode_exit got %h/%b want %h/000",
                     out_time, flash, tv(2, 0, 0, 0));
            n_fail++;
        end
        ticks(3);
        pulse(0, 1, 0, 0, 0);
        idle();
        n_checks++;
        if (out_time !== tv(2, 0, 0, 3)) begin
            $display("FAIL set_keep_t got %h want %h",
                     out_time, tv(2, 0, 0, 3));
            n_fail++;
        end
        pulse(1, 0, 0, 0, 0);
        idle();
        n_checks++;
        if (out_time !== tv(2, 0, 0, 0)) begin
            $display("FAIL exit_clr_t got %h want %h",
                     out_time, tv(2, 0, 0, 0));
            n_fail++;
        end
    endtask

    task automatic test_stopwatch();
        pulse(1, 0, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        ticks(600);
        idle();
        n_checks++;
        if (out_time !== tv(0, 1, 0, 0) || display_mode !== 1'b1) begin
            $display("FAIL sw_600 got %h/%b want %h/1",
                     out_time, display_mode, tv(0, 1, 0, 0));
            n_fail++;
        end
        pulse(1, 0, 0, 0, 0);
        idle();
        n_checks++;
        if (out_time !== tv(2, 1, 0, 0) || display_mode !== 1'b0) begin
            $display("FAIL tod_bg got %h/%b want %h/0",
                     out_time, display_mode, tv(2, 1, 0, 0));
            n_fail++;
        end
        ticks(5);
        pulse(1, 0, 0, 0, 0);
        idle();
        n_checks++;
        if (out_time !== tv(0, 1, 0, 5)) begin
            $display("FAIL sw_bg got %h want %h",
                     out_time, tv(0, 1, 0, 5));
            n_fail++;
        end
        pulse(1, 0, 0, 1, 0);
        ticks(3);
        pulse(1, 0, 0, 0, 0);
        idle();
        n_checks++;
        if (out_time !== tv(0, 1, 0, 5)) begin
            $display("FAIL mode_start got %h want %h",
                     out_time, tv(0, 1, 0, 5));
            n_fail++;
        end
    endtask

    task automatic test_clear();
        pulse(0, 0, 1, 0, 1);
        idle();
        n_checks++;
        if (out_time !== 21'd0) begin
            $display("FAIL sw_clear got %h want 0", out_time);
            n_fail++;
        end
        pulse(0, 0, 0, 1, 0);
        ticks(7);
        pulse(0, 0, 1, 0, 0);
        idle();
        n_checks++;
        if (out_time !== tv(0, 0, 0, 7)) begin
            $display("FAIL run_inc got %h want %h",
                     out_time, tv(0, 0, 0, 7));
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        idle();
        n_checks++;
        if (out_time !== tv(2, 1, 1, 6) || flash !== 3'b010) begin
            $display("FAIL pre_rst got %h/%b want %h/010",
                     out_time, flash, tv(2, 1, 1, 6));
            n_fail++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_time !== 21'd0 || flash !== 3'b000 ||
            display_mode !== 1'b0) begin
            $display("FAIL async_rst got %h/%b/%b want 0/000/0",
                     out_time, flash, display_mode);
            n_fail++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        ticks(5);
        idle();
        n_checks++;
        if (out_time !== tv(0, 0, 0, 5) || flash !== 3'b000) begin
            $display("FAIL post_rst got %h/%b want %h/000",
                     out_time, flash, tv(0, 0, 0, 5));
            n_fail++;
        end
        pulse(1, 0, 0, 0, 0);
        idle();
        n_checks++;
        if (out_time !== 21'd0 || display_mode !== 1'b1) begin
            $display("FAIL sw_stopped got %h/%b want 0/1",
                     out_time, display_mode);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 1);
        idle();
        n_checks++;
        if (out_time !== 21'd0 || display_mode !== 1'b1) begin
            $display("FAIL tick_mode got %h/%b want 0/1",
                     out_time, display_mode);
            n_fail++;
        end
        pulse(1, 0, 0, 0, 0);
        idle();
        n_checks++;
        if (out_time !== tv(0, 0, 0, 6) || display_mode !== 1'b0) begin
            $display("FAIL tick_mode_tod got %h/%b want %h/0",
                     out_time, display_mode, tv(0, 0, 0, 6));
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_wrap();
        test_set_h();
        test_stopwatch();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
